// File: rtl/cdma_wg_rd_req_credit_pipe.sv
// cdma_wg_rd_req_credit_pipe: WG read-request skid + credit gate + output register toward MC.
// Optional CDMA_WG_RDREQ_PERF_EN adds a saturating credit-stall cycle counter.
module cdma_wg_rd_req_credit_pipe #(
  parameter int PD_W       = 79,
  parameter int CREDIT_MAX = 128,
  parameter int CNT_W      = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             dma_rd_req_vld,
  input  logic [PD_W-1:0]  dma_rd_req_pd,
  output logic             dma_rd_req_rdy,
  output logic             mc_int_rd_req_valid,
  output logic [PD_W-1:0]  mc_int_rd_req_pd,
  input  logic             mc_int_rd_req_ready,
  input  logic             rsp_credit_pop,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err,
  output logic [31:0]      perf_credit_stall
);
  // need is kept at full size-field width so an oversize request can never alias to a small one
  localparam int NEED_W = PD_W - 64 + 1;
  localparam int SUM_W  = CNT_W + 1;
  logic              r_rdy, r_a_vld, r_s_vld, r_b_vld, r_err;
  logic [PD_W-1:0]   r_a_pd, r_s_pd, r_b_pd;
  logic [CNT_W-1:0]  r_cnt;
  logic [NEED_W-1:0] w_need;
  logic [CNT_W-1:0]  w_dec;
  logic [SUM_W-1:0]  w_sum;
  logic              w_acc, w_free, w_ok, w_move, w_over, w_s_vld_nxt;
  assign w_need      = NEED_W'(r_a_pd[PD_W-1:64]) + NEED_W'(1);
  assign w_acc       = dma_rd_req_vld && r_rdy;
  assign w_free      = !r_b_vld || mc_int_rd_req_ready;
  assign w_ok        = NEED_W'(r_cnt) >= w_need;
  assign w_move      = r_a_vld && w_free && w_ok;
  assign w_dec       = w_move ? w_need[CNT_W-1:0] : '0;
  assign w_sum       = SUM_W'(r_cnt - w_dec) + SUM_W'(rsp_credit_pop);
  assign w_over      = w_sum > SUM_W'(CREDIT_MAX);
  assign w_s_vld_nxt = r_s_vld ? !w_move : (w_acc && r_a_vld && !w_move);
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_rdy   <= 1'b1;
      r_a_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_b_vld <= 1'b0;
      r_b_pd  <= '0;
      r_cnt   <= CNT_W'(CREDIT_MAX);
      r_err   <= 1'b0;
    end else begin
      r_a_vld <= w_move ? (r_s_vld || w_acc) : (r_a_vld || w_acc);
      r_s_vld <= w_s_vld_nxt;
      r_rdy   <= !w_s_vld_nxt;
      if (w_move) begin
        r_b_vld <= 1'b1;
        r_b_pd  <= r_a_pd;
      end else if (mc_int_rd_req_ready) begin
        r_b_vld <= 1'b0;
      end
      r_cnt <= w_over ? CNT_W'(CREDIT_MAX) : w_sum[CNT_W-1:0];
      if (w_over) r_err <= 1'b1;
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (w_move && r_s_vld) r_a_pd <= r_s_pd;
    else if (w_acc && (w_move || !r_a_vld)) r_a_pd <= dma_rd_req_pd;
    if (w_acc && r_a_vld && !w_move) r_s_pd <= dma_rd_req_pd;
  end
`ifdef CDMA_WG_RDREQ_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_stall <= '0;
    else if (r_a_vld && w_free && !w_ok && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign perf_credit_stall = r_stall;
`else
  assign perf_credit_stall = '0;
`endif
  // a request needing more than the whole FIFO can never be granted
  a_need_legal: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    r_a_vld |-> w_need <= NEED_W'(CREDIT_MAX));
  assign dma_rd_req_rdy      = r_rdy;
  assign mc_int_rd_req_valid = r_b_vld;
  assign mc_int_rd_req_pd    = r_b_pd;
  assign credit_cnt          = r_cnt;
  assign credit_err          = r_err;
endmodule
